qsn_inverse_controller_85b: RTL and testbench

//  Return-path (de-permutation) controller for the 85-lane QSN circular shifter.
//  - Records each forward shift factor in arrival order.
//  - When the matching check-node message block comes back, pops that factor.
//  - Drives registered left/right/merge selects that rotate the block back by the

---
 rtl/qsn_pkg.sv | 39 +++
 rtl/shift_factor_fifo.sv | 53 +++++
 rtl/qsn_inverse_controller_85b.sv | 79 +++++++
 tb/tb_qsn_inverse_controller_85b.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qsn_pkg.sv
// Shared QSN constants, select bundle type and the inverse-shift / merge-mask helpers.
package qsn_pkg;

  localparam int unsigned QSN_Z       = 85;
  localparam int unsigned QSN_SHIFT_W = 7;
  localparam int unsigned QSN_MERGE_W = 84;

  typedef struct packed {
    logic [QSN_SHIFT_W-1:0] left_sel;
    logic [QSN_SHIFT_W-1:0] right_sel;
    logic [QSN_MERGE_W-1:0] merge_sel;
  } qsn_sel_t;

  // Inverse rotation amount; zero and out-of-range factors map to identity.
  function automatic logic [QSN_SHIFT_W-1:0] qsn_inv_shift(input logic [QSN_SHIFT_W-1:0] s);
    logic [QSN_SHIFT_W:0] k;
    if (s == '0 || 32'(s) >= QSN_Z) begin
      k = '0;
    end else begin
      k = (QSN_SHIFT_W+1)'(QSN_Z) - {1'b0, s};
    end
    return k[QSN_SHIFT_W-1:0];
  endfunction

  // Merge mask: low (Z-k) lanes set; k=0 selects every lane.
  function automatic logic [QSN_MERGE_W-1:0] qsn_merge_mask(input logic [QSN_SHIFT_W-1:0] k);
    logic [QSN_MERGE_W-1:0] m;
    int unsigned n;
    m = '1;
    if (k != '0) begin
      n = QSN_Z - 32'(k);
      for (int unsigned i = 0; i < QSN_MERGE_W; i++) begin
        m[i] = (i < n);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/shift_factor_fifo.sv
// Synchronous FIFO holding forward shift factors until their blocks return.
module shift_factor_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qsn_inverse_controller_85b.sv
// Return-path QSN controller: pops forward factors and registers inverse-rotation selects.
module qsn_inverse_controller_85b
  import qsn_pkg::*;
#(
  parameter int unsigned PERMUTATION_LENGTH = QSN_Z,
  parameter int unsigned SHIFT_W            = QSN_SHIFT_W,
  parameter int unsigned FIFO_DEPTH         = 8
) (
  input  logic                              sys_clk,
  input  logic                              rstn,
  input  logic                              fwd_valid,
  input  logic [SHIFT_W-1:0]                fwd_shift,
  output logic                              fwd_ready,
  input  logic                              ret_valid,
  output logic                              ret_ready,
  output logic [SHIFT_W-1:0]                left_sel,
  output logic [SHIFT_W-1:0]                right_sel,
  output logic [PERMUTATION_LENGTH-2:0]     merge_sel,
  output logic                              sel_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              err_range
);

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [SHIFT_W-1:0] head;
  logic [SHIFT_W-1:0] inv_k;
  qsn_sel_t           sel_next;

  assign fwd_ready = ~full;
  assign ret_ready = ~empty;
  assign push      = fwd_valid & fwd_ready;
  assign pop       = ret_valid & ret_ready;

  shift_factor_fifo #(
    .WIDTH (SHIFT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (fwd_shift),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Inverse selects for the factor at the FIFO head.
  always_comb begin
    inv_k              = qsn_inv_shift(head);
    sel_next.left_sel  = inv_k;
    sel_next.right_sel = (inv_k == '0) ? '0 : SHIFT_W'(PERMUTATION_LENGTH) - inv_k;
    sel_next.merge_sel = qsn_merge_mask(inv_k);
  end

  // Output registers: selects update only on a pop; range error is sticky.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      left_sel  <= '0;
      right_sel <= '0;
      merge_sel <= '0;
      sel_valid <= 1'b0;
      err_range <= 1'b0;
    end else begin
      sel_valid <= pop;
      if (pop) begin
        left_sel  <= sel_next.left_sel;
        right_sel <= sel_next.right_sel;
        merge_sel <= sel_next.merge_sel;
      end
      if (push && fwd_shift >= SHIFT_W'(PERMUTATION_LENGTH)) err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qsn_inverse_controller_85b.sv
// Scoreboard bench for qsn_inverse_controller_85b with a queue-based reference model.
module tb_qsn_inverse_controller_85b;

  logic        sys_clk;
  logic        rstn;
  logic        fwd_valid;
  logic [6:0]  fwd_shift;
  logic        fwd_ready;
  logic        ret_valid;
  logic        ret_ready;
  logic [6:0]  left_sel;
  logic [6:0]  right_sel;
  logic [83:0] merge_sel;
  logic        sel_valid;
  logic [3:0]  level;
  logic        err_range;

  qsn_inverse_controller_85b #(
    .PERMUTATION_LENGTH (85),
    .SHIFT_W            (7),
    .FIFO_DEPTH         (8)
  ) dut (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .fwd_valid (fwd_valid),
    .fwd_shift (fwd_shift),
    .fwd_ready (fwd_ready),
    .ret_valid (ret_valid),
    .ret_ready (ret_ready),
    .left_sel  (left_sel),
    .right_sel (right_sel),
    .merge_sel (merge_sel),
    .sel_valid (sel_valid),
    .level     (level),
    .err_range (err_range)
  );

  typedef struct {
    logic [6:0]  s;
    logic [6:0]  l;
    logic [6:0]  r;
    logic [83:0] m;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  int          n_pops = 0;
  bit          mon_en = 0;
  bit          m_err  = 0;
  logic [6:0]  mq[$];
  exp_t        exp_q[$];
  exp_t        mon_e;

  initial sys_clk = 0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: rotate back by 85-s; merge covers the low (85-k) lanes.
  function automatic exp_t make_exp(input logic [6:0] s);
    exp_t        e;
    int unsigned k;
    logic [83:0] one;
    one = 84'd1;
    k = (s == 0 || s >= 85) ? 0 : 85 - int'(s);
    e.s = s;
    e.l = 7'(k);
    e.r = (k == 0) ? 7'd0 : 7'(85 - k);
    e.m = (k == 0) ? '1 : (one << (85 - k)) - one;
    return e;
  endfunction

  function automatic logic [84:0] rotl(input logic [84:0] x, input int unsigned r);
    logic [84:0] y;
    y = '0;
    for (int unsigned i = 0; i < 85; i++) y[(i + r) % 85] = x[i];
    return y;
  endfunction

  task automatic cycle(input bit fv, input logic [6:0] fs, input bit rv);
    bit do_push;
    bit do_pop;
    @(negedge sys_clk);
    fwd_valid = fv;
    fwd_shift = fs;
    ret_valid = rv;
    do_push = fv && (mq.size() < 8);
    do_pop  = rv && (mq.size() > 0);
    @(posedge sys_clk);
    if (do_pop) begin
      exp_q.push_back(make_exp(mq.pop_front()));
      n_pops++;
    end
    if (do_push) begin
      mq.push_back(fs);
      if (fs >= 85) m_err = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    mon_en = 0;
    rstn = 0;
    #1;
    chk("rst_left_sel",  128'(left_sel),  128'(0));
    chk("rst_right_sel", 128'(right_sel), 128'(0));
    chk("rst_merge_sel", 128'(merge_sel), 128'(0));
    chk("rst_sel_valid", 128'(sel_valid), 128'(0));
    chk("rst_err_range", 128'(err_range), 128'(0));
    chk("rst_level",     128'(level),     128'(0));
    chk("rst_ret_ready", 128'(ret_ready), 128'(0));
    chk("rst_fwd_ready", 128'(fwd_ready), 128'(1));
    mq.delete();
    exp_q.delete();
    m_err = 0;
    fwd_valid = 0;
    ret_valid = 0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #2;
    rstn = 1;
    #1;
    mon_en = 1;
    chk("post_rst_level",     128'(level),     128'(0));
    chk("post_rst_ret_ready", 128'(ret_ready), 128'(0));
  endtask

  // Monitor: status against the model every cycle; selects against the scoreboard on sel_valid.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      chk("level",     128'(level),     128'(mq.size()));
      chk("fwd_ready", 128'(fwd_ready), 128'(mq.size() != 8));
      chk("ret_ready", 128'(ret_ready), 128'(mq.size() != 0));
      chk("err_range", 128'(err_range), 128'(m_err));
      if (sel_valid) begin
        if (exp_q.size() == 0) begin
          chk("sel_valid_spurious", 128'(1), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("left_sel",  128'(left_sel),  128'(mon_e.l));
          chk("right_sel", 128'(right_sel), 128'(mon_e.r));
          chk("merge_sel", 128'(merge_sel), 128'(mon_e.m));
          if (mon_e.s < 85) begin
            logic [84:0] x;
            x = {21'($urandom), $urandom, $urandom};
            chk("inverse_rotation", 128'(rotl(rotl(x, int'(mon_e.s)), int'(left_sel))), 128'(x));
          end
        end
      end else if (exp_q.size() != 0) begin
        chk("sel_valid_missing", 128'(0), 128'(1));
        mon_e = exp_q.pop_front();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rstn = 0;
    fwd_valid = 0;
    fwd_shift = '0;
    ret_valid = 0;
    do_reset();

    // Single round trip
    cycle(1, 7'd1, 0);
    cycle(0, 7'd0, 1);
    cycle(0, 7'd0, 0);

    // Order and identity
    cycle(1, 7'd0, 0);
    cycle(1, 7'd42, 0);
    cycle(1, 7'd84, 0);
    repeat (3) cycle(0, 7'd0, 1);
    cycle(0, 7'd0, 0);

    // Fill, push while full, drain to 4, push+pop at 4, then empty pops
    for (int i = 0; i < 8; i++) cycle(1, 7'($urandom_range(0, 84)), 0);
    #1;
    chk("full_fwd_ready", 128'(fwd_ready), 128'(0));
    chk("full_level",     128'(level),     128'(8));
    cycle(1, 7'd5, 0);
    repeat (4) cycle(0, 7'd0, 1);
    cycle(1, 7'd7, 1);
    #1;
    chk("push_pop_level", 128'(level), 128'(4));
    repeat (4) cycle(0, 7'd0, 1);
    cycle(0, 7'd0, 1);
    cycle(0, 7'd0, 1);
    #1;
    chk("empty_ret_ready", 128'(ret_ready), 128'(0));
    chk("empty_sel_valid", 128'(sel_valid), 128'(0));

    // Range error
    cycle(1, 7'd90, 0);
    #1;
    chk("range_err_set", 128'(err_range), 128'(1));
    cycle(0, 7'd0, 1);
    cycle(0, 7'd0, 0);
    cycle(0, 7'd0, 0);
    chk("range_err_sticky", 128'(err_range), 128'(1));

    // Mid-operation reset discards outstanding factors
    cycle(1, 7'd10, 0);
    cycle(1, 7'd20, 1);
    cycle(1, 7'd30, 0);
    do_reset();
    cycle(0, 7'd0, 1);
    cycle(0, 7'd0, 0);

    // Random soak
    n_pops = 0;
    cyc = 0;
    while (n_pops < 10000 && cyc < 60000) begin
      logic [6:0] s;
      s = ($urandom_range(0, 99) < 97) ? 7'($urandom_range(0, 84)) : 7'($urandom_range(85, 127));
      cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0);
      cyc++;
    end
    chk("soak_budget", 128'(n_pops >= 10000), 128'(1));
    while (mq.size() > 0 && cyc < 60100) begin
      cycle(0, 7'd0, 1);
      cyc++;
    end
    cycle(0, 7'd0, 0);
    cycle(0, 7'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
